// File: rtl/gpu_pkg.sv
// Shared types for the branch resolution path: state and control-flow class enums,
// the instruction size, and the class priority encoder.
package gpu_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        CF_PLAIN  = 3'd0,
        CF_BRANCH = 3'd1,
        CF_JAL    = 3'd2,
        CF_JALR   = 3'd3,
        CF_HALT   = 3'd4
    } cf_class_e;

    // Several decode flags may be set at once; the strongest one wins.
    function automatic cf_class_e cf_encode(
        input logic is_branch,
        input logic is_jal,
        input logic is_jalr,
        input logic is_halt
    );
        if (is_jal)         return CF_JAL;
        else if (is_jalr)   return CF_JALR;
        else if (is_branch) return CF_BRANCH;
        else if (is_halt)   return CF_HALT;
        else                return CF_PLAIN;
    endfunction

endpackage

// File: rtl/branch_resolve_target_calc.sv
// Combinational next-PC / link / redirect / misalignment computation for one
// decoded control-flow instruction. All sums wrap modulo 2^ADDRESS_WIDTH.
module branch_target_calc
    import gpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  cf_class_e                i_class,
    input  logic [ADDRESS_WIDTH-1:0] i_pc,
    input  logic [ADDRESS_WIDTH-1:0] i_imm,
    input  logic [ADDRESS_WIDTH-1:0] i_rs1,
    input  logic                     i_cmp_result,
    output logic [ADDRESS_WIDTH-1:0] o_next_pc,
    output logic [ADDRESS_WIDTH-1:0] o_link,
    output logic                     o_redirect,
    output logic                     o_misaligned
);

    logic [ADDRESS_WIDTH-1:0] w_seq_pc;
    logic [ADDRESS_WIDTH-1:0] w_rel_pc;
    logic [ADDRESS_WIDTH-1:0] w_reg_pc;

    always_comb begin
        w_seq_pc = i_pc + ADDRESS_WIDTH'(INSTR_BYTES);
        w_rel_pc = i_pc + i_imm;
        // JALR target has bit0 forced low, as the ISA defines.
        w_reg_pc = (i_rs1 + i_imm) & ~ADDRESS_WIDTH'(1);

        case (i_class)
            CF_JAL:    o_next_pc = w_rel_pc;
            CF_JALR:   o_next_pc = w_reg_pc;
            CF_BRANCH: o_next_pc = i_cmp_result ? w_rel_pc : w_seq_pc;
            CF_HALT:   o_next_pc = i_pc;
            default:   o_next_pc = w_seq_pc;
        endcase

        o_link       = w_seq_pc;
        o_redirect   = (o_next_pc != w_seq_pc);
        // Bit0 is already clear for every target, so only bit1 can misalign.
        o_misaligned = o_redirect && o_next_pc[1];
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: one-entry registered result with valid/ready on both
// sides, plus a run/halt FSM. Optional statistics counters under BRANCH_STATS_EN.
module branch_resolve
    import gpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
`ifdef BRANCH_STATS_EN
    ,
    parameter int STATS_WIDTH = 32
`endif
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] in_pc,
    input  logic [ADDRESS_WIDTH-1:0] in_imm,
    input  logic [ADDRESS_WIDTH-1:0] in_rs1,
    input  logic                     is_branch,
    input  logic                     is_jal,
    input  logic                     is_jalr,
    input  logic                     is_halt,
    input  logic                     cmp_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_pc_next,
    output logic [ADDRESS_WIDTH-1:0] out_link,
    output logic                     out_redirect,
    output logic                     out_misaligned,
    output logic                     halted,
    input  logic                     run
`ifdef BRANCH_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]   stat_taken,
    output logic [STATS_WIDTH-1:0]   stat_not_taken,
    output logic [STATS_WIDTH-1:0]   stat_jumps
`endif
);

    state_e                   r_state;
    state_e                   w_state_next;
    cf_class_e                w_class;
    logic                     w_accept;
    logic [ADDRESS_WIDTH-1:0] w_next_pc;
    logic [ADDRESS_WIDTH-1:0] w_link;
    logic                     w_redirect;
    logic                     w_misaligned;

    logic                     r_out_valid;
    logic [ADDRESS_WIDTH-1:0] r_pc_next;
    logic [ADDRESS_WIDTH-1:0] r_link;
    logic                     r_redirect;
    logic                     r_misaligned;

    assign w_class  = cf_encode(is_branch, is_jal, is_jalr, is_halt);
    assign w_accept = in_valid && in_ready;

    branch_target_calc #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_calc (
        .i_class       (w_class),
        .i_pc          (in_pc),
        .i_imm         (in_imm),
        .i_rs1         (in_rs1),
        .i_cmp_result  (cmp_result),
        .o_next_pc     (w_next_pc),
        .o_link        (w_link),
        .o_redirect    (w_redirect),
        .o_misaligned  (w_misaligned)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_pc_next    <= '0;
            r_link       <= '0;
            r_redirect   <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_pc_next    <= w_next_pc;
            r_link       <= w_link;
            r_redirect   <= w_redirect;
            r_misaligned <= w_misaligned;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_pc_next    = r_pc_next;
    assign out_link       = r_link;
    assign out_redirect   = r_redirect;
    assign out_misaligned = r_misaligned;

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= RUN;
        else          r_state <= w_state_next;
    end

    // A halt (or misaligned target) accepted together with run still halts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:    if (w_accept && (w_class == CF_HALT || w_misaligned)) w_state_next = HALTED;
            HALTED: if (run) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        halted   = (r_state == HALTED);
        in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
    end

`ifdef BRANCH_STATS_EN
    logic [STATS_WIDTH-1:0] r_taken;
    logic [STATS_WIDTH-1:0] r_not_taken;
    logic [STATS_WIDTH-1:0] r_jumps;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_taken     <= '0;
            r_not_taken <= '0;
            r_jumps     <= '0;
        end else if (w_accept) begin
            if (w_class == CF_BRANCH && cmp_result && r_taken != '1)
                r_taken <= r_taken + 1'b1;
            if (w_class == CF_BRANCH && !cmp_result && r_not_taken != '1)
                r_not_taken <= r_not_taken + 1'b1;
            if ((w_class == CF_JAL || w_class == CF_JALR) && r_jumps != '1)
                r_jumps <= r_jumps + 1'b1;
        end
    end

    assign stat_taken     = r_taken;
    assign stat_not_taken = r_not_taken;
    assign stat_jumps     = r_jumps;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve; stats checks compile in when
// BRANCH_STATS_EN is defined.
module tb_branch_resolve;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [31:0] in_rs1;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_halt;
    logic        cmp_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_next;
    logic [31:0] out_link;
    logic        out_redirect;
    logic        out_misaligned;
    logic        halted;
    logic        run;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_not_taken;
    logic [31:0] stat_jumps;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    branch_resolve dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_rs1         (in_rs1),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .is_halt        (is_halt),
        .cmp_result     (cmp_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc_next    (out_pc_next),
        .out_link       (out_link),
        .out_redirect   (out_redirect),
        .out_misaligned (out_misaligned),
        .halted         (halted),
        .run            (run)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
        .stat_jumps     (stat_jumps)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one instruction for exactly one edge; flags = {branch, jal, jalr, halt}.
    task automatic send(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [3:0] flags, input logic cmp);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_imm     = imm;
        in_rs1     = rs1;
        {is_branch, is_jal, is_jalr, is_halt} = flags;
        cmp_result = cmp;
        tick();
        in_valid   = 1'b0;
        {is_branch, is_jal, is_jalr, is_halt} = 4'b0000;
        cmp_result = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; run = 1'b0;
        in_pc = '0; in_imm = '0; in_rs1 = '0;
        {is_branch, is_jal, is_jalr, is_halt} = 4'b0000; cmp_result = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_pc_next !== 32'h0) $display("FAIL reset_pc: got %h want 0", out_pc_next); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_branch();
        send(32'h100, 32'h20, 32'h0, 4'b1000, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL br_taken_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_pc_next !== 32'h120) $display("FAIL br_taken_pc: got %h want 120", out_pc_next); else n_pass++;
        n_total++; if ({out_redirect, out_misaligned} !== 2'b10) $display("FAIL br_taken_flags: got %b want 10", {out_redirect, out_misaligned}); else n_pass++;
        send(32'h100, 32'h20, 32'h0, 4'b1000, 1'b0);
        n_total++; if (out_pc_next !== 32'h104) $display("FAIL br_not_pc: got %h want 104", out_pc_next); else n_pass++;
        n_total++; if (out_redirect !== 1'b0) $display("FAIL br_not_redirect: got %b want 0", out_redirect); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL br_drain: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_jalr_priority();
        send(32'h40, 32'h10, 32'h2001, 4'b0010, 1'b0);
        n_total++; if (out_pc_next !== 32'h2010) $display("FAIL jalr_pc: got %h want 2010", out_pc_next); else n_pass++;
        n_total++; if (out_link !== 32'h44) $display("FAIL jalr_link: got %h want 44", out_link); else n_pass++;
        n_total++; if ({out_redirect, out_misaligned} !== 2'b10) $display("FAIL jalr_flags: got %b want 10", {out_redirect, out_misaligned}); else n_pass++;
        // jal beats jalr and branch
        send(32'h100, 32'h8, 32'h5000, 4'b1110, 1'b0);
        n_total++; if (out_pc_next !== 32'h108) $display("FAIL prio_jal_pc: got %h want 108", out_pc_next); else n_pass++;
        // branch beats halt; untaken branch stays sequential and does not halt
        send(32'h200, 32'h40, 32'h0, 4'b1001, 1'b0);
        n_total++; if (out_pc_next !== 32'h204) $display("FAIL prio_br_pc: got %h want 204", out_pc_next); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL prio_br_halted: got %b want 0", halted); else n_pass++;
        // cmp_result must not affect a plain instruction
        send(32'h300, 32'h40, 32'h0, 4'b0000, 1'b1);
        n_total++; if (out_pc_next !== 32'h304) $display("FAIL plain_cmp_pc: got %h want 304", out_pc_next); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(32'h1000, 32'h0, 32'h0, 4'b0000, 1'b0);
        in_valid = 1'b1; in_pc = 32'h2000;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", in_ready); else n_pass++;
        tick(); tick();
        n_total++; if (out_pc_next !== 32'h1004 || out_valid !== 1'b1) $display("FAIL bp_hold: got %h/%b want 1004/1", out_pc_next, out_valid); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_high: got %b want 1", in_ready); else n_pass++;
        tick();
        n_total++; if (out_pc_next !== 32'h2004 || out_valid !== 1'b1) $display("FAIL b2b_first: got %h/%b want 2004/1", out_pc_next, out_valid); else n_pass++;
        in_pc = 32'h3000;
        tick();
        n_total++; if (out_pc_next !== 32'h3004 || out_valid !== 1'b1) $display("FAIL b2b_second: got %h/%b want 3004/1", out_pc_next, out_valid); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_halt();
        send(32'h80, 32'h40, 32'h0, 4'b0001, 1'b0);
        n_total++; if (out_pc_next !== 32'h80) $display("FAIL halt_pc: got %h want 80", out_pc_next); else n_pass++;
        n_total++; if ({halted, in_ready, out_redirect} !== 3'b101) $display("FAIL halt_state: got %b want 101", {halted, in_ready, out_redirect}); else n_pass++;
        tick();
        n_total++; if ({out_valid, halted} !== 2'b01) $display("FAIL halt_drain: got %b want 01", {out_valid, halted}); else n_pass++;
        pulse_run();
        n_total++; if ({halted, in_ready} !== 2'b01) $display("FAIL halt_resume: got %b want 01", {halted, in_ready}); else n_pass++;
        send(32'h10, 32'h0, 32'h0, 4'b0000, 1'b0);
        n_total++; if (out_pc_next !== 32'h14 || out_valid !== 1'b1) $display("FAIL halt_after: got %h/%b want 14/1", out_pc_next, out_valid); else n_pass++;
        run = 1'b1;
        send(32'h90, 32'h0, 32'h0, 4'b0001, 1'b0);
        run = 1'b0;
        n_total++; if (halted !== 1'b1) $display("FAIL halt_run_same: got %b want 1", halted); else n_pass++;
        tick();
        n_total++; if (halted !== 1'b1) $display("FAIL halt_stays: got %b want 1", halted); else n_pass++;
        pulse_run();
    endtask

    task automatic test_misaligned_wrap();
        send(32'h0, 32'h6, 32'h0, 4'b0100, 1'b0);
        n_total++; if (out_pc_next !== 32'h6 || out_link !== 32'h4) $display("FAIL mis_pc_link: got %h/%h want 6/4", out_pc_next, out_link); else n_pass++;
        n_total++; if ({out_misaligned, halted} !== 2'b11) $display("FAIL mis_halt: got %b want 11", {out_misaligned, halted}); else n_pass++;
        tick();
        pulse_run();
        send(32'hFFFF_FFFC, 32'h0, 32'h0, 4'b0000, 1'b0);
        n_total++; if (out_pc_next !== 32'h0 || out_link !== 32'h0) $display("FAIL wrap: got %h/%h want 0/0", out_pc_next, out_link); else n_pass++;
        n_total++; if ({out_redirect, halted} !== 2'b00) $display("FAIL wrap_flags: got %b want 00", {out_redirect, halted}); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'h500, 32'h0, 32'h0, 4'b0000, 1'b0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL mid_held: got %b want 1", out_valid); else n_pass++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        n_total++; if (out_valid !== 1'b0 || out_pc_next !== 32'h0) $display("FAIL mid_reset: got %b/%h want 0/0", out_valid, out_pc_next); else n_pass++;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_total++; if ({stat_taken, stat_not_taken, stat_jumps} !== 96'h0) $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", stat_taken, stat_not_taken, stat_jumps); else n_pass++;
        for (int i = 0; i < 3; i++) send(32'h100, 32'h20, 32'h0, 4'b1000, 1'b1);
        for (int i = 0; i < 2; i++) send(32'h100, 32'h20, 32'h0, 4'b1000, 1'b0);
        send(32'h100, 32'h8, 32'h0, 4'b0100, 1'b0);
        n_total++; if (stat_taken !== 32'd3) $display("FAIL stats_taken: got %0d want 3", stat_taken); else n_pass++;
        n_total++; if (stat_not_taken !== 32'd2) $display("FAIL stats_not_taken: got %0d want 2", stat_not_taken); else n_pass++;
        n_total++; if (stat_jumps !== 32'd1) $display("FAIL stats_jumps: got %0d want 1", stat_jumps); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_branch();
        test_jalr_priority();
        test_back_to_back();
        test_halt();
        test_misaligned_wrap();
        test_reset_mid();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
